// File: rtl/alu_issue_ctrl_pkg.sv
// Shared encodings for the ALU issue controller: op-codes, FSM states and
// the width of one queued request entry.
package alu_ctrl_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    // Two 64-bit operands plus the 2-bit select; the tag rides on top.
    localparam int REQ_BASE_W = 130;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } ctrl_state_t;

    function automatic int req_entry_w(input int tag_w);
        return REQ_BASE_W + tag_w;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request and response handshakes of the ALU issue controller.
// master = decode/writeback side, slave = the controller.
interface alu_issue_if #(
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [63:0]      req_a;
    logic [63:0]      req_b;
    logic [TAG_W-1:0] req_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [63:0]      rsp_result;
    logic             rsp_ovf;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_ovf, rsp_tag
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_ovf, rsp_tag
    );
endinterface

// File: rtl/alu_issue_ctrl_req_fifo.sv
// Circular-buffer request FIFO; head entry is visible combinationally on
// pop_data, and a push only becomes visible on the following cycle.
module alu_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 134
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues queued requests to the external combinational ALU and returns tagged
// results. Optional sticky overflow flag under `ALU_OVF_STICKY_EN.
module alu_issue_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_issue_if.slave  bus,
    output logic [63:0] alu_a,
    output logic [63:0] alu_b,
    output logic [1:0]  alu_sel,
    input  logic [63:0] alu_result,
    input  logic        alu_ovf,
`ifdef ALU_OVF_STICKY_EN
    input  logic        ovf_clr,
    output logic        ovf_sticky,
`endif
    output logic        busy
);
    localparam int ENTRY_W = req_entry_w(TAG_W);
    localparam int CNT_W   = $clog2(DEPTH + 1);

    ctrl_state_t        state;
    ctrl_state_t        next_state;
    logic               ready_en;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic [TAG_W-1:0]   held_tag;
    logic               rsp_valid_q;
    logic [63:0]        rsp_result_q;
    logic               rsp_ovf_q;
    logic [TAG_W-1:0]   rsp_tag_q;

    assign push_entry     = {bus.req_tag, bus.req_op, bus.req_a, bus.req_b};
    assign bus.req_ready  = ready_en && !fifo_full;
    assign fifo_push      = bus.req_valid && bus.req_ready;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_ovf    = rsp_ovf_q;
    assign bus.rsp_tag    = rsp_tag_q;
    assign busy           = (fifo_count != '0) || (state != ST_IDLE);

    alu_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Keeps req_ready low until the first clock after reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        fifo_pop   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: next_state = ST_RESP;
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        next_state = ST_ISSUE;
                    end else begin
                        next_state = ST_IDLE;
                    end
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Operand registers change only on a pop; response registers only in
    // ISSUE, so a stalled response stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a        <= '0;
            alu_b        <= '0;
            alu_sel      <= '0;
            held_tag     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_ovf_q    <= 1'b0;
            rsp_tag_q    <= '0;
        end else begin
            if (fifo_pop) begin
                held_tag <= head_entry[ENTRY_W-1 -: TAG_W];
                alu_sel  <= head_entry[129:128];
                alu_a    <= head_entry[127:64];
                alu_b    <= head_entry[63:0];
            end
            if (state == ST_ISSUE) begin
                rsp_result_q <= alu_result;
                rsp_ovf_q    <= alu_ovf;
                rsp_tag_q    <= held_tag;
                rsp_valid_q  <= 1'b1;
            end else if (state == ST_RESP && bus.rsp_ready) begin
                rsp_valid_q  <= 1'b0;
            end
        end
    end

`ifdef ALU_OVF_STICKY_EN
    // Set has priority over clear when both land in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (rsp_valid_q && bus.rsp_ready && rsp_ovf_q) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural stand-in for the ALU.
// Build with ALU_OVF_STICKY_EN defined to also exercise the sticky flag.
module tb_alu_issue_ctrl;
    import alu_ctrl_pkg::*;

    typedef struct {
        logic [63:0] result;
        logic        ovf;
        logic [3:0]  tag;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [1:0]  alu_sel;
    logic [63:0] alu_result;
    logic        alu_ovf;
    logic        busy;
`ifdef ALU_OVF_STICKY_EN
    logic        ovf_clr;
    logic        ovf_sticky;
`endif

    int   total = 0;
    int   bad = 0;
    int   hs_count = 0;
    exp_t sb[$];

    alu_issue_if #(.TAG_W(4)) bus ();

    alu_issue_ctrl #(
        .DEPTH (4),
        .TAG_W (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .alu_ovf    (alu_ovf),
`ifdef ALU_OVF_STICKY_EN
        .ovf_clr    (ovf_clr),
        .ovf_sticky (ovf_sticky),
`endif
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the combinational 64-bit ALU the controller drives.
    always_comb begin
        alu_result = '0;
        alu_ovf    = 1'b0;
        case (alu_sel)
            OP_ADD: begin
                alu_result = alu_a + alu_b;
                alu_ovf    = (alu_a[63] == alu_b[63]) && (alu_result[63] != alu_a[63]);
            end
            OP_SUB: begin
                alu_result = alu_a - alu_b;
                alu_ovf    = (alu_a[63] != alu_b[63]) && (alu_result[63] != alu_a[63]);
            end
            OP_AND:  alu_result = alu_a & alu_b;
            default: alu_result = alu_a ^ alu_b;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", tag, actual, expected);
        end
    endtask

    // Response monitor: every handshake is matched against the scoreboard head.
    always @(negedge clk) begin
        if (bus.rsp_valid && bus.rsp_ready) begin
            exp_t e;
            hs_count++;
            if (sb.size() == 0) begin
                checkOutput("unexpected_rsp", 64'(bus.rsp_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                checkOutput($sformatf("rsp_result_tag%0d", e.tag), bus.rsp_result, e.result);
                checkOutput($sformatf("rsp_ovf_tag%0d", e.tag), 64'(bus.rsp_ovf), 64'(e.ovf));
                checkOutput($sformatf("rsp_tag_tag%0d", e.tag), 64'(bus.rsp_tag), 64'(e.tag));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge or budget expiry.
    task automatic applyStimulus(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                                 input logic [3:0] tag, input logic [63:0] exp_r, input logic exp_o,
                                 input int budget, output bit accepted);
        exp_t e;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_tag   = tag;
        accepted      = 1'b0;
        for (int i = 0; i < budget && !accepted; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                accepted = 1'b1;
                e.result = exp_r;
                e.ovf    = exp_o;
                e.tag    = tag;
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic sendReq(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                           input logic [3:0] tag, input logic [63:0] exp_r, input logic exp_o);
        bit acc;
        applyStimulus(op, a, b, tag, exp_r, exp_o, 20, acc);
        checkOutput($sformatf("accept_tag%0d", tag), 64'(acc), 64'd1);
    endtask

    task automatic waitDrain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) begin
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            checkOutput("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit acc;
        int n_acc;
        int hs0;

        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_tag   = '0;
        bus.rsp_ready = 1'b1;
`ifdef ALU_OVF_STICKY_EN
        ovf_clr       = 1'b0;
`endif
        #12;
        checkOutput("rst_req_ready", 64'(bus.req_ready), 64'd0);
        checkOutput("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_alu_a", alu_a, 64'd0);
        checkOutput("rst_alu_sel", 64'(alu_sel), 64'd0);
        checkOutput("rst_rsp_result", bus.rsp_result, 64'd0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_req_ready", 64'(bus.req_ready), 64'd1);

        $display("[TB] single ADD latency");
        sendReq(OP_ADD, 64'd5, 64'd7, 4'd3, 64'd12, 1'b0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("lat_valid_t1", 64'(bus.rsp_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("lat_valid_t2", 64'(bus.rsp_valid), 64'd1);
        waitDrain(20);

        $display("[TB] overflow and logic ops");
        sendReq(OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'd1, 64'h8000_0000_0000_0000, 1'b1);
        sendReq(OP_SUB, 64'h8000_0000_0000_0000, 64'd1, 4'd2, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
        sendReq(OP_AND, 64'hF0F0, 64'hFF00, 4'd4, 64'hF000, 1'b0);
        sendReq(OP_XOR, 64'hF0F0, 64'hFF00, 4'd5, 64'h0FF0, 1'b0);
        waitDrain(40);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("hold_alu_sel", 64'(alu_sel), 64'(OP_XOR));
        checkOutput("hold_alu_a", alu_a, 64'hF0F0);
        checkOutput("hold_alu_b", alu_b, 64'hFF00);
        checkOutput("idle_busy", 64'(busy), 64'd0);

        $display("[TB] backpressure stream");
        bus.rsp_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(OP_ADD, 64'(i), 64'd100, 4'(i), 64'(i + 100), 1'b0, 3, acc);
            if (acc) n_acc++;
        end
        checkOutput("stream_accepted", 64'(n_acc), 64'd5);
        checkOutput("full_req_ready", 64'(bus.req_ready), 64'd0);
        checkOutput("stall_valid", 64'(bus.rsp_valid), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("stall_tag", 64'(bus.rsp_tag), 64'd0);
        checkOutput("stall_result", bus.rsp_result, 64'd100);
        checkOutput("stall_valid_held", 64'(bus.rsp_valid), 64'd1);
        bus.rsp_ready = 1'b1;
        hs0 = hs_count;
        repeat (10) @(negedge clk);
        checkOutput("throughput_10cyc", 64'(hs_count - hs0), 64'd5);
        waitDrain(20);

        $display("[TB] reset during ISSUE");
        bus.rsp_ready = 1'b0;
        n_acc = 0;
        for (int i = 8; i < 13; i++) begin
            applyStimulus(OP_ADD, 64'(i), 64'd100, 4'(i), 64'(i + 100), 1'b0, 3, acc);
            if (acc) n_acc++;
        end
        checkOutput("rst_fill_accepted", 64'(n_acc), 64'd5);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        checkOutput("pre_rst_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_req_ready", 64'(bus.req_ready), 64'd0);
        checkOutput("midrst_alu_a", alu_a, 64'd0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        hs0 = hs_count;
        repeat (8) @(posedge clk);
        #1;
        checkOutput("no_stale_rsp", 64'(hs_count - hs0), 64'd0);
        checkOutput("post_midrst_req_ready", 64'(bus.req_ready), 64'd1);
        sendReq(OP_ADD, 64'd20, 64'd22, 4'd6, 64'd42, 1'b0);
        waitDrain(20);

`ifdef ALU_OVF_STICKY_EN
        $display("[TB] sticky overflow");
        checkOutput("sticky_after_rst", 64'(ovf_sticky), 64'd0);
        sendReq(OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'd7, 64'h8000_0000_0000_0000, 1'b1);
        waitDrain(20);
        sendReq(OP_ADD, 64'd1, 64'd2, 4'd8, 64'd3, 1'b0);
        sendReq(OP_AND, 64'hFF, 64'h0F, 4'd9, 64'h0F, 1'b0);
        sendReq(OP_SUB, 64'd10, 64'd4, 4'd10, 64'd6, 1'b0);
        waitDrain(30);
        checkOutput("sticky_held", 64'(ovf_sticky), 64'd1);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        checkOutput("sticky_cleared", 64'(ovf_sticky), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Sequential front-end that issues operations to the combinational 64-bit ALU (add/sub/and/xor + overflow).
- Accepts operation requests over a valid/ready interface into a small FIFO.
- Drives the ALU operand and select lines from registers and captures the ALU result and overflow.
- Returns each result, tagged, on a valid/ready response interface.
- Sits between instruction decode and writeback; it is the requesting side of the ALU's Selectline/operand interface.

Parameters:
DEPTH, 4, request FIFO entries (power of two, ≥2)
TAG_W, 4, width of the request tag carried through to the response

Ports:
clk  in  1  single clock; all state on rising edge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  FIFO can accept
req_op  in  2  00 ADD, 01 SUB, 10 AND, 11 XOR (same encoding as ALU select)
req_a  in  64  signed operand A
req_b  in  64  signed operand B
req_tag  in  TAG_W  opaque tag
alu_a  out  64  registered operand A to ALU
alu_b  out  64  registered operand B to ALU
alu_sel  out  2  registered select to ALU
alu_result  in  64  ALU combinational result
alu_ovf  in  1  ALU overflow flag
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts
rsp_result  out  64  captured result
rsp_ovf  out  1  captured overflow
rsp_tag  out  TAG_W  tag of the request
busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset values:
  - FIFO empty; all outputs 0; FSM IDLE.
  - req_ready goes to 1 only after reset deasserts.
- Request handshake:
  - Push on req_valid && req_ready.
  - req_ready = (count != DEPTH), registered count only; no combinational path from rsp_ready or any pop.
- FSM: IDLE, ISSUE, RESP.
  - IDLE: if FIFO non-empty, pop the head into alu_a/alu_b/alu_sel and the held tag, then go to ISSUE.
  - ISSUE: capture alu_result/alu_ovf into rsp_result/rsp_ovf, copy the tag to rsp_tag, set rsp_valid=1, go to RESP.
  - RESP: hold every rsp_* output stable while rsp_valid && !rsp_ready. On handshake, clear rsp_valid. Then either pop the head into the operand registers and go to ISSUE if the FIFO is non-empty (back-to-back), or go to IDLE.
- Latency:
  - Push at edge t into an empty idle block: pop at t+1, rsp_valid at t+2.
  - Sustained throughput: one operation per 2 cycles with rsp_ready held high.
- FIFO:
  - Circular buffer with log2(DEPTH)-bit pointers wrapping modulo DEPTH, plus a count of DEPTH+1 range.
  - Simultaneous push and pop in the same cycle: count unchanged, both pointers advance.
  - A pop of an entry pushed in the same cycle is not possible; a push becomes visible the next cycle.
- Arithmetic: none inside the block. Result and overflow pass through from the ALU unmodified; AND/XOR overflow is whatever the ALU reports (0).
- Operand registers hold their last value outside ISSUE. alu_* outputs change only on a pop.
- Reset mid-operation:
  - Asynchronously clears FIFO, FSM and rsp_valid.
  - In-flight and queued requests are discarded; no response is produced for them.

Optional Feature:
Macro ALU_OVF_STICKY_EN.
- Defined:
  - Adds input ovf_clr (1) and output ovf_sticky (1), reset 0.
  - ovf_sticky sets on any response handshake with rsp_ovf=1.
  - ovf_sticky clears on ovf_clr. Set wins if both occur in the same cycle.
- Undefined: neither port exists; behaviour otherwise identical.

Decomposition:
- Package alu_ctrl_pkg:
  - Op-code localparams OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_XOR=2'b11.
  - FSM state encoding ST_IDLE/ST_ISSUE/ST_RESP.
  - Request entry width constant 130+TAG_W.
- One sub-module: alu_req_fifo (parameterised DEPTH and width; push/pop/full/empty/count).

Test Plan:
- ADD a=5, b=7, tag=3 with rsp_ready=1 -> rsp_valid 2 cycles after accept; rsp_result=12, rsp_ovf=0, rsp_tag=3.
- ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> rsp_result=0x8000_0000_0000_0000, rsp_ovf=1. SUB a=0x8000_0000_0000_0000, b=1 -> 0x7FFF_FFFF_FFFF_FFFF, rsp_ovf=1.
- AND 0xF0F0 & 0xFF00 -> 0xF000. XOR 0xF0F0 ^ 0xFF00 -> 0x0FF0. Both rsp_ovf=0.
- rsp_ready=0, stream requests tagged 0..7 -> exactly 5 accepted (1 held in RESP + 4 queued), then req_ready=0 and rsp outputs stable. Raise rsp_ready -> tags 0..4 returned in order, one per 2 cycles.
- Assert rst_n=0 during ISSUE with 3 queued -> same cycle rsp_valid=0, busy=0. After release, no stale response; next request returns normally.
- (ALU_OVF_STICKY_EN) overflowing ADD, then 3 clean ops -> ovf_sticky stays 1. Pulse ovf_clr -> 0.
